// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and widths for the ALU issue controller and its request FIFO.
// Latency: none, types only.
// Backpressure: not applicable.
package alu_pkg;

    localparam int OPCODE_W = 3;
    localparam int DTYPE_W  = 1;
    localparam int DATA_W   = 32;
    localparam int IW_W     = OPCODE_W + DTYPE_W + 2 * DATA_W;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [DTYPE_W-1:0]  data_type;
        logic [DATA_W-1:0]   operand_a;
        logic [DATA_W-1:0]   operand_b;
    } alu_iw_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/result handshake bundle between a command source and the issue controller.
// Latency: wires only.
// Backpressure: req_ready throttles requests, res_ready throttles results.
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic                          req_valid;
    logic                          req_ready;
    logic [alu_pkg::OPCODE_W-1:0]  req_opcode;
    logic [alu_pkg::DTYPE_W-1:0]   req_data_type;
    logic [alu_pkg::DATA_W-1:0]    req_operand_a;
    logic [alu_pkg::DATA_W-1:0]    req_operand_b;
    logic                          res_valid;
    logic                          res_ready;
    logic [alu_pkg::DATA_W-1:0]    res_data;
    logic [TAG_W-1:0]              res_tag;

    modport master (
        output req_valid, req_opcode, req_data_type, req_operand_a, req_operand_b, res_ready,
        input  req_ready, res_valid, res_data, res_tag
    );

    modport slave (
        input  req_valid, req_opcode, req_data_type, req_operand_a, req_operand_b, res_ready,
        output req_ready, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/alu_issue_ctrl_fifo.sv
// Synchronous request FIFO holding packed instruction words with their tags.
// Latency: a push is visible on pop_dat/empty one cycle later (no bypass).
// Backpressure: push ignored while full, pop ignored while empty.
module alu_req_fifo #(
    parameter int W     = 72,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues queued ALU requests one at a time and returns tagged results in order.
// Latency: accept edge P -> result valid after edge P+2+ALU_LATENCY when idle.
// Backpressure: req_ready drops when the FIFO is full; results hold until res_ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 0,
    parameter int TAG_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    output logic [IW_W-1:0]   iw,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy
);
    localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam int ENT_W = IW_W + TAG_W;

    issue_state_t      state, state_nxt;
    alu_iw_t           req_iw, pop_iw, iw_q;
    logic [TAG_W-1:0]  pop_tag, pend_tag, tag_cnt, res_tag_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] res_data_q;
    logic              res_valid_q;
    logic [ENT_W-1:0]  fifo_rd_dat;
    logic              fifo_full, fifo_empty;
    logic              push, pop, cap;

    assign req_iw = '{opcode:    bus.req_opcode,
                      data_type: bus.req_data_type,
                      operand_a: bus.req_operand_a,
                      operand_b: bus.req_operand_b};

    // Ready is gated by reset so nothing can be accepted while the block is held.
    assign bus.req_ready = rst_n && !fifo_full;
    assign push          = bus.req_valid && bus.req_ready;
    assign {pop_iw, pop_tag} = fifo_rd_dat;

    alu_req_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({req_iw, tag_cnt}),
        .pop      (pop),
        .pop_dat  (fifo_rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        cap       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    cap       = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            iw_q        <= '0;
            pend_tag    <= '0;
            cnt         <= '0;
            tag_cnt     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
        end else begin
            state <= state_nxt;
            if (push) tag_cnt <= tag_cnt + 1'b1;
            if (pop) begin
                iw_q     <= pop_iw;
                pend_tag <= pop_tag;
                cnt      <= CNT_W'(ALU_LATENCY);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (cap) begin
                res_valid_q <= 1'b1;
                res_data_q  <= alu_out;
                res_tag_q   <= pend_tag;
            end else if (state == HOLD && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign iw            = iw_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_tag   = res_tag_q;
    assign busy          = !fifo_empty || (state != IDLE);
endmodule
